// File: rtl/decode_stage_pkg.sv
//==============================================================================
// decode_stage_pkg : ISA constants, field positions and FSM encodings
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

package decode_stage_pkg;

  localparam int          DATA_W      = 16;
  localparam int          REG_IDX_W   = 3;
  localparam logic [15:0] NOP_INSTR_C = 16'h0800;
  localparam logic [4:0]  HALT_OPC_C  = 5'b00000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 8;
  localparam int RT_MSB  = 7;
  localparam int RT_LSB  = 5;
  localparam int RD_MSB  = 4;
  localparam int RD_LSB  = 2;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  function automatic logic is_halt(input logic [4:0] opc, input logic [4:0] halt_opc);
    return opc == halt_opc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_rf_bypass.sv
//==============================================================================
// rf_bypass : NUM_REGS x WIDTH register file, 2 read / 1 write, write-through
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_bypass #(
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [IDX_W-1:0] i_rd0_idx,
  input  logic [IDX_W-1:0] i_rd1_idx,
  output logic [WIDTH-1:0] o_rd0_data,
  output logic [WIDTH-1:0] o_rd1_data
);

  logic [WIDTH-1:0] r_regs [NUM_REGS];

  // A write arriving with reset asserted is discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_regs[i_wr_idx] <= i_wr_data;
    end
  end

  logic w_byp0;
  logic w_byp1;

  assign w_byp0 = i_wr_en && (i_wr_idx == i_rd0_idx);
  assign w_byp1 = i_wr_en && (i_wr_idx == i_rd1_idx);

  assign o_rd0_data = w_byp0 ? i_wr_data : r_regs[i_rd0_idx];
  assign o_rd1_data = w_byp1 ? i_wr_data : r_regs[i_rd1_idx];

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
//==============================================================================
// decode_stage : IF/ID latch, bypassed register file, field/immediate decode,
//                HALT detection and PC enable back to fetch
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int          WIDTH       = DATA_W,
  parameter int          NUM_REGS    = 8,
  parameter logic [15:0] NOP_INSTR   = NOP_INSTR_C,
  parameter logic [4:0]  HALT_OPCODE = HALT_OPC_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instruc,
  input  logic [WIDTH-1:0] seq_PC,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [2:0]       wb_reg,
  input  logic [WIDTH-1:0] wb_data,
  output logic             en_PC,
  output logic [WIDTH-1:0] id_instr,
  output logic [WIDTH-1:0] id_seq_PC,
  output logic             id_valid,
  output logic [2:0]       rs_num,
  output logic [2:0]       rt_num,
  output logic [2:0]       rd_num,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] imm5_s,
  output logic [WIDTH-1:0] imm5_z,
  output logic [WIDTH-1:0] imm8_s,
  output logic [WIDTH-1:0] disp11_s,
  output logic             halt
);

  logic [WIDTH-1:0] r_id_instr;
  logic [WIDTH-1:0] r_id_seq_pc;
  logic             r_id_valid;
  logic [0:0]       r_state;

  logic             w_halt_in_id;
  logic             w_halt_take;

  assign w_halt_in_id = r_id_valid && is_halt(r_id_instr[OPC_MSB:OPC_LSB], HALT_OPCODE);
  // A flush squashes the HALT sitting in IF/ID, so it never takes effect.
  assign w_halt_take  = (r_state == ST_RUN) && w_halt_in_id && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_id_instr  <= NOP_INSTR;
      r_id_seq_pc <= '0;
      r_id_valid  <= 1'b0;
      r_state     <= ST_RUN;
    end else if (w_halt_take) begin
      r_id_instr  <= NOP_INSTR;
      r_id_valid  <= 1'b0;
      r_state     <= ST_HALTED;
    end else if (r_state == ST_HALTED) begin
      r_state     <= ST_HALTED;
    end else if (flush) begin
      r_id_instr  <= NOP_INSTR;
      r_id_valid  <= 1'b0;
    end else if (!stall) begin
      r_id_instr  <= instruc;
      r_id_seq_pc <= seq_PC;
      r_id_valid  <= 1'b1;
    end
  end

  assign en_PC = rst && (r_state == ST_RUN) && !stall && !(w_halt_in_id && !flush);
  assign halt  = (r_state == ST_HALTED);

  assign id_instr  = r_id_instr;
  assign id_seq_PC = r_id_seq_pc;
  assign id_valid  = r_id_valid;

  assign rs_num = r_id_instr[RS_MSB:RS_LSB];
  assign rt_num = r_id_instr[RT_MSB:RT_LSB];
  assign rd_num = r_id_instr[RD_MSB:RD_LSB];

  assign imm5_s   = {{(WIDTH-5){r_id_instr[4]}},   r_id_instr[4:0]};
  assign imm5_z   = {{(WIDTH-5){1'b0}},            r_id_instr[4:0]};
  assign imm8_s   = {{(WIDTH-8){r_id_instr[7]}},   r_id_instr[7:0]};
  assign disp11_s = {{(WIDTH-11){r_id_instr[10]}}, r_id_instr[10:0]};

  rf_bypass #(
    .NUM_REGS (NUM_REGS),
    .WIDTH    (WIDTH),
    .IDX_W    (REG_IDX_W)
  ) u_rf (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (wb_en),
    .i_wr_idx   (wb_reg),
    .i_wr_data  (wb_data),
    .i_rd0_idx  (rs_num),
    .i_rd1_idx  (rt_num),
    .o_rd0_data (rs_data),
    .o_rd1_data (rt_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//==============================================================================
// tb_decode_stage : directed + randomized checks of decode_stage against a
//                   behavioural model
// Rev 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruc, seq_PC, wb_data;
  logic        stall, flush, wb_en;
  logic [2:0]  wb_reg;
  logic        en_PC, id_valid, halt;
  logic [15:0] id_instr, id_seq_PC, rs_data, rt_data, imm5_s, imm5_z, imm8_s, disp11_s;
  logic [2:0]  rs_num, rt_num, rd_num;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .instruc(instruc), .seq_PC(seq_PC),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .en_PC(en_PC), .id_instr(id_instr), .id_seq_PC(id_seq_PC), .id_valid(id_valid),
    .rs_num(rs_num), .rt_num(rt_num), .rd_num(rd_num),
    .rs_data(rs_data), .rt_data(rt_data),
    .imm5_s(imm5_s), .imm5_z(imm5_z), .imm8_s(imm8_s), .disp11_s(disp11_s),
    .halt(halt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model state
  logic [15:0] m_regs [8];
  logic [15:0] m_instr, m_pc;
  logic        m_valid, m_halted;

  function automatic logic [15:0] sx(input int v);
    return 16'(v);
  endfunction

  task automatic check_outputs();
    int          rs, rt;
    logic        halt_id;
    logic [15:0] e_rs, e_rt;
    rs      = int'(m_instr / 256) % 8;
    rt      = int'(m_instr / 32) % 8;
    halt_id = m_valid && (m_instr < 16'h0800);
    e_rs    = (wb_en && int'(wb_reg) == rs) ? wb_data : m_regs[rs];
    e_rt    = (wb_en && int'(wb_reg) == rt) ? wb_data : m_regs[rt];
    chk("id_instr",  id_instr,  m_instr);
    chk("id_seq_PC", id_seq_PC, m_pc);
    chk("id_valid",  16'(id_valid), 16'(m_valid));
    chk("halt",      16'(halt),     16'(m_halted));
    chk("en_PC",     16'(en_PC),    16'(rst && !m_halted && !stall && !(halt_id && !flush)));
    chk("rs_num",    16'(rs_num),   16'(rs));
    chk("rt_num",    16'(rt_num),   16'(rt));
    chk("rd_num",    16'(rd_num),   16'(int'(m_instr / 4) % 8));
    chk("rs_data",   rs_data, e_rs);
    chk("rt_data",   rt_data, e_rt);
    chk("imm5_s",    imm5_s,   sx($signed(m_instr[4:0])));
    chk("imm5_z",    imm5_z,   16'(int'(m_instr % 32)));
    chk("imm8_s",    imm8_s,   sx($signed(m_instr[7:0])));
    chk("disp11_s",  disp11_s, sx($signed(m_instr[10:0])));
  endtask

  task automatic update_model();
    logic halt_id;
    halt_id = m_valid && (m_instr < 16'h0800);
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_instr = 16'h0800; m_pc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
    end else begin
      if (wb_en) m_regs[wb_reg] = wb_data;
      if (!m_halted && halt_id && !flush) begin
        m_halted = 1'b1; m_instr = 16'h0800; m_valid = 1'b0;
      end else if (m_halted) begin
        // frozen until reset
      end else if (flush) begin
        m_instr = 16'h0800; m_valid = 1'b0;
      end else if (!stall) begin
        m_instr = instruc; m_pc = seq_PC; m_valid = 1'b1;
      end
    end
  endtask

  // Inputs are already set at a falling edge; check, then clock once.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic we,
                       input logic [2:0] wr, input logic [15:0] wd,
                       input logic [15:0] ins, input logic [15:0] pc);
    rst = r; stall = s; flush = f; wb_en = we; wb_reg = wr; wb_data = wd;
    instruc = ins; seq_PC = pc;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_regs[i] = 16'hxxxx;
    m_instr = 16'hxxxx; m_pc = 16'hxxxx; m_valid = 1'bx; m_halted = 1'bx;
    drive(0, 0, 0, 0, 0, 0, 16'h4123, 16'h0002);
    @(negedge clk);
    @(posedge clk); update_model(); @(negedge clk);
    chk("reset_id_instr", id_instr, 16'h0800);
    chk("reset_en_PC",    16'(en_PC), 16'h0000);

    // Load after reset
    drive(1, 0, 0, 0, 0, 0, 16'h4123, 16'h0002); tick();
    chk("load_id_instr", id_instr, 16'h4123);
    chk("load_valid",    16'(id_valid), 16'h0001);

    // Same-cycle bypass on rs (rs_num = 1 for 4123; put 0x4300 in to get rs=3)
    drive(1, 0, 0, 0, 0, 0, 16'h4360, 16'h0004); tick();
    drive(1, 1, 0, 1, 3, 16'hBEEF, 16'h5555, 16'h0006); tick();
    chk("bypass_written", rs_data, 16'hBEEF);

    // Stall two cycles with changing instruc, then flush+stall
    drive(1, 1, 0, 0, 0, 0, 16'h6001, 16'h0008); tick();
    drive(1, 1, 0, 0, 0, 0, 16'h6002, 16'h000A); tick();
    chk("stall_hold", id_instr, 16'h4360);
    drive(1, 1, 1, 0, 0, 0, 16'h6003, 16'h000C); tick();
    chk("flush_bubble", id_instr, 16'h0800);

    // Immediates: 001F is a HALT encoding, so reset afterwards
    drive(1, 0, 0, 0, 0, 0, 16'h001F, 16'h000E); tick();
    chk("imm5_s_FFFF", imm5_s, 16'hFFFF);
    drive(1, 0, 0, 0, 0, 0, 16'h7777, 16'h0010); tick();
    chk("halt_set", 16'(halt), 16'h0001);
    drive(0, 0, 0, 1, 2, 16'h1234, 16'h0480, 16'h0000); tick();
    chk("rst_clears_halt", 16'(halt), 16'h0000);
    drive(1, 0, 0, 0, 0, 0, 16'h0480, 16'h0002); tick();
    chk("disp11_FC80", disp11_s, 16'hFC80);
    chk("imm8_FF80",   imm8_s,   16'hFF80);
    drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000); tick();

    // Randomized run
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 29) != 0 && ins[15:11] == 5'b00000) ins[15:11] = 5'b00001;
      drive((m_halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 49) == 0 ? 1'b0 : 1'b1,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            3'($urandom), 16'($urandom), ins, 16'($urandom));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
